// File: rtl/heater_pkg.sv
// Shared types and LFSR helpers for the heater_array power-burn block.
// Latency: none, pure functions and constants.
// Backpressure: none, no flow-controlled interfaces.
package heater_pkg;

  // Galois (right-shift) tap masks for the supported word widths.
  localparam logic [63:0] TAPS16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] TAPS32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] TAPS64 = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} ramp_state_t;

  function automatic logic [63:0] width_mask(input int unsigned w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // One LFSR step on the low w bits; upper bits of the result are zero.
  function automatic logic [63:0] lfsr_next(input logic [63:0] q, input int unsigned w);
    logic [63:0] taps;
    logic [63:0] r;
    taps = (w == 16) ? TAPS16 : ((w == 64) ? TAPS64 : TAPS32);
    r = q >> 1;
    if (q[0]) r = r ^ taps;
    return r & width_mask(w);
  endfunction

  // Distinct nonzero start value per channel so channels never toggle in lockstep.
  function automatic logic [63:0] seed(input int unsigned k, input int unsigned w);
    logic [63:0] s;
    s = (64'h5A5A_C3C3_1234_ABCD + 64'(k) * 64'h0001_0003_0007_0101) & width_mask(w);
    if (s == 64'd0) s = 64'd1;
    return s;
  endfunction

endpackage

// File: rtl/heater_channel.sv
// One heater lane: LFSR generator -> DEPTH-stage pipeline -> self-synchronising checker.
// Latency: a generated word reaches the checker DEPTH running cycles later; mismatch is combinational.
// Backpressure: ch_en low freezes every register in the lane; optional HEATER_ERR_INJECT_EN adds inj.
module heater_channel
  import heater_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int CH    = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ch_en,
`ifdef HEATER_ERR_INJECT_EN
  input  logic inj,
`endif
  output logic mismatch
);

  logic [WIDTH-1:0] gen_q;
  logic [WIDTH-1:0] stage0_dat;
  logic [WIDTH-1:0] pipe_dat [DEPTH];
  logic [DEPTH-1:0] pipe_vld;
  logic [WIDTH-1:0] prev_dat;
  logic             prev_vld;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
    logic [63:0] v64;
    v64 = '0;
    v64[WIDTH-1:0] = v;
    return WIDTH'(lfsr_next(v64, WIDTH));
  endfunction

`ifdef HEATER_ERR_INJECT_EN
  assign stage0_dat = gen_q ^ {{(WIDTH-1){1'b0}}, inj};
`else
  assign stage0_dat = gen_q;
`endif

  // Generator, pipeline and checker history all advance together so a freeze stays coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_q    <= WIDTH'(seed(CH, WIDTH));
      for (int i = 0; i < DEPTH; i++) pipe_dat[i] <= '0;
      pipe_vld <= '0;
      prev_dat <= '0;
      prev_vld <= 1'b0;
    end else if (ch_en) begin
      gen_q       <= step(gen_q);
      pipe_dat[0] <= stage0_dat;
      pipe_vld[0] <= 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_dat[i] <= pipe_dat[i-1];
        pipe_vld[i] <= pipe_vld[i-1];
      end
      prev_dat <= pipe_dat[DEPTH-1];
      prev_vld <= pipe_vld[DEPTH-1];
    end
  end

  // Only an advancing cycle with two valid consecutive words is checked.
  assign mismatch = ch_en & pipe_vld[DEPTH-1] & prev_vld &
                    (pipe_dat[DEPTH-1] != step(prev_dat));

endmodule

// File: rtl/heater_array.sv
// NCH heater lanes under a one-at-a-time ramp controller, with sticky error aggregation.
// Latency: channel steps every RAMP_CYCLES cycles; errors register one cycle after a mismatch.
// Backpressure: none; enable is a level request. HEATER_ERR_INJECT_EN adds the inj_ch port.
module heater_array
  import heater_pkg::*;
#(
  parameter int NCH         = 8,
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 128,
  parameter int RAMP_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NCH-1:0]             ch_mask,
  input  logic                       err_clear,
`ifdef HEATER_ERR_INJECT_EN
  input  logic [NCH-1:0]             inj_ch,
`endif
  output logic                       error,
  output logic [NCH-1:0]             err_ch,
  output logic [15:0]                err_count,
  output logic [$clog2(NCH+1)-1:0]   active_cnt,
  output logic                       busy
);

  localparam int CW = $clog2(NCH+1);
  localparam int TW = $clog2(RAMP_CYCLES+1);
  localparam logic [TW-1:0] TMR_LAST = TW'(RAMP_CYCLES-1);

  ramp_state_t    state, state_nxt;
  logic [TW-1:0]  tmr, tmr_nxt;
  logic [NCH-1:0] ch_en, ch_en_nxt;
  logic [NCH-1:0] mask_q, mask_nxt;
  logic [NCH-1:0] up_pick, dn_pick;
  logic [NCH-1:0] mm;
  logic           tmr_done;

  assign tmr_done = (tmr == TMR_LAST);

  // Lowest masked channel still off, and highest channel on, as one-hot picks.
  always_comb begin
    up_pick = '0;
    dn_pick = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      if (mask_q[k] && !ch_en[k]) begin
        up_pick    = '0;
        up_pick[k] = 1'b1;
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (ch_en[k]) begin
        dn_pick    = '0;
        dn_pick[k] = 1'b1;
      end
    end
  end

  // Ramp next state: each direction change restarts the step timer.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    ch_en_nxt = ch_en;
    mask_nxt  = mask_q;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RAMP_UP;
          mask_nxt  = ch_mask;
          tmr_nxt   = '0;
        end
      end
      RAMP_UP: begin
        if (!enable) begin
          state_nxt = RAMP_DOWN;
          tmr_nxt   = '0;
        end else if ((mask_q & ~ch_en) == '0) begin
          state_nxt = RUN;
        end else if (tmr_done) begin
          ch_en_nxt = ch_en | up_pick;
          tmr_nxt   = '0;
          if ((mask_q & ~ch_en_nxt) == '0) state_nxt = RUN;
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = RAMP_DOWN;
          tmr_nxt   = '0;
        end
      end
      RAMP_DOWN: begin
        if (enable) begin
          state_nxt = RAMP_UP;
          tmr_nxt   = '0;
        end else if (ch_en == '0) begin
          state_nxt = IDLE;
        end else if (tmr_done) begin
          ch_en_nxt = ch_en & ~dn_pick;
          tmr_nxt   = '0;
          if (ch_en_nxt == '0) state_nxt = IDLE;
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ramp state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      tmr    <= '0;
      ch_en  <= '0;
      mask_q <= '0;
    end else begin
      state  <= state_nxt;
      tmr    <= tmr_nxt;
      ch_en  <= ch_en_nxt;
      mask_q <= mask_nxt;
    end
  end

  // Sticky flags and saturating count; a fresh mismatch beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_ch    <= '0;
      err_count <= '0;
    end else begin
      err_ch <= (err_clear ? '0 : err_ch) | mm;
      if (|mm) begin
        if (err_clear)                 err_count <= 16'd1;
        else if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (err_clear) begin
        err_count <= '0;
      end
    end
  end

  // Running-channel count follows ch_en directly.
  always_comb begin
    active_cnt = '0;
    for (int k = 0; k < NCH; k++) active_cnt = active_cnt + CW'(ch_en[k]);
  end

  assign busy  = (state != IDLE);
  assign error = |err_ch;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    heater_channel #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CH    (k)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .ch_en    (ch_en[k]),
`ifdef HEATER_ERR_INJECT_EN
      .inj      (inj_ch[k]),
`endif
      .mismatch (mm[k])
    );
  end

endmodule

// File: tb/tb_heater_array.sv
// Self-checking bench for heater_array: directed vector table, hand sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a. Exercises injection when HEATER_ERR_INJECT_EN is defined.
module tb_heater_array;
  localparam int NCH = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int RC = 16;
  localparam int CW = $clog2(NCH+1);

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic [NCH-1:0] ch_mask;
  logic           err_clear;
  logic           error;
  logic [NCH-1:0] err_ch;
  logic [15:0]    err_count;
  logic [CW-1:0]  active_cnt;
  logic           busy;
`ifdef HEATER_ERR_INJECT_EN
  logic [NCH-1:0] inj_ch;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  heater_array #(
    .NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .RAMP_CYCLES(RC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .ch_mask    (ch_mask),
    .err_clear  (err_clear),
`ifdef HEATER_ERR_INJECT_EN
    .inj_ch     (inj_ch),
`endif
    .error      (error),
    .err_ch     (err_ch),
    .err_count  (err_count),
    .active_cnt (active_cnt),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 ramping up, 2 running, 3 ramping down.
  int             m_phase;
  int             m_cnt;
  logic [NCH-1:0] m_mask;
  int             m_on[$];

  function automatic int lowest_missing();
    bit found;
    for (int k = 0; k < NCH; k++) begin
      if (m_mask[k]) begin
        found = 0;
        foreach (m_on[j]) if (m_on[j] == k) found = 1;
        if (!found) return k;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_mask  = '0;
    m_on.delete();
  endtask

  task automatic model_step(input logic en, input logic [NCH-1:0] mask);
    int mi;
    case (m_phase)
      0: if (en) begin m_phase = 1; m_mask = mask; m_cnt = 0; end
      1: begin
        if (!en) begin m_phase = 3; m_cnt = 0; end
        else if (lowest_missing() < 0) m_phase = 2;
        else begin
          m_cnt++;
          if (m_cnt == RC) begin
            m_on.push_back(lowest_missing());
            m_cnt = 0;
            if (lowest_missing() < 0) m_phase = 2;
          end
        end
      end
      2: if (!en) begin m_phase = 3; m_cnt = 0; end
      default: begin
        if (en) begin m_phase = 1; m_cnt = 0; end
        else if (m_on.size() == 0) m_phase = 0;
        else begin
          m_cnt++;
          if (m_cnt == RC) begin
            mi = 0;
            foreach (m_on[j]) if (m_on[j] > m_on[mi]) mi = j;
            m_on.delete(mi);
            m_cnt = 0;
            if (m_on.size() == 0) m_phase = 0;
          end
        end
      end
    endcase
  endtask

  typedef struct {
    logic           en;
    logic [NCH-1:0] mask;
    int             n;
    int             cnt;
    logic           bsy;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hold;

    tbl[0]  = '{1'b1, 4'hF, 16,  0, 1'b1};
    tbl[1]  = '{1'b1, 4'hF, 1,   1, 1'b1};
    tbl[2]  = '{1'b1, 4'hF, 16,  2, 1'b1};
    tbl[3]  = '{1'b1, 4'hF, 15,  2, 1'b1};
    tbl[4]  = '{1'b1, 4'hF, 1,   3, 1'b1};
    tbl[5]  = '{1'b1, 4'hF, 16,  4, 1'b1};
    tbl[6]  = '{1'b1, 4'hF, 100, 4, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 16,  4, 1'b1};
    tbl[8]  = '{1'b0, 4'hF, 1,   3, 1'b1};
    tbl[9]  = '{1'b0, 4'hF, 16,  2, 1'b1};
    tbl[10] = '{1'b0, 4'hF, 16,  1, 1'b1};
    tbl[11] = '{1'b0, 4'hF, 15,  1, 1'b1};
    tbl[12] = '{1'b0, 4'hF, 1,   0, 1'b0};
    tbl[13] = '{1'b1, 4'hA, 17,  1, 1'b1};
    tbl[14] = '{1'b1, 4'hA, 16,  2, 1'b1};
    tbl[15] = '{1'b1, 4'hF, 40,  2, 1'b1};
    tbl[16] = '{1'b0, 4'hF, 16,  2, 1'b1};
    tbl[17] = '{1'b0, 4'hF, 17,  0, 1'b0};
    tbl[18] = '{1'b1, 4'h0, 2,   0, 1'b1};
    tbl[19] = '{1'b0, 4'h0, 1,   0, 1'b1};
    tbl[20] = '{1'b0, 4'h0, 1,   0, 1'b0};

    reset_n   = 1'b0;
    enable    = 1'b0;
    ch_mask   = '0;
    err_clear = 1'b0;
`ifdef HEATER_ERR_INJECT_EN
    inj_ch    = '0;
`endif
    #12;
    check("rst_cnt",   32'(active_cnt), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_err",   32'(error),      32'd0);
    check("rst_errch", 32'(err_ch),     32'd0);
    check("rst_count", 32'(err_count),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed ramp table.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      enable  = tbl[i].en;
      ch_mask = tbl[i].mask;
      run_edges(tbl[i].n);
      check($sformatf("vec%0d_cnt", i),  32'(active_cnt), 32'(tbl[i].cnt));
      check($sformatf("vec%0d_busy", i), 32'(busy),       32'(tbl[i].bsy));
      check($sformatf("vec%0d_err", i),  32'(error),      32'd0);
    end

    // Reverse during ramp-up at two channels, then resume.
    @(negedge clk); enable = 1'b1; ch_mask = 4'hF;
    run_edges(33);
    check("rev_up_cnt", 32'(active_cnt), 32'd2);
    @(negedge clk); enable = 1'b0;
    run_edges(5);
    check("rev_dn_cnt", 32'(active_cnt), 32'd2);
    check("rev_dn_busy", 32'(busy), 32'd1);
    @(negedge clk); enable = 1'b1;
    run_edges(16);
    check("rev_resume_hold", 32'(active_cnt), 32'd2);
    run_edges(1);
    check("rev_resume_step", 32'(active_cnt), 32'd3);
    run_edges(120);
    check("rev_run_cnt",   32'(active_cnt), 32'd4);
    check("rev_run_err",   32'(error),      32'd0);
    check("rev_run_count", 32'(err_count),  32'd0);

`ifdef HEATER_ERR_INJECT_EN
    // Single-cycle corruption on ch2 produces exactly two mismatching checks.
    @(negedge clk); inj_ch = 4'b0100;
    run_edges(1);
    inj_ch = '0;
    run_edges(12);
    check("inj_errch", 32'(err_ch),    32'h4);
    check("inj_error", 32'(error),     32'd1);
    check("inj_count", 32'(err_count), 32'd2);
    @(negedge clk); err_clear = 1'b1;
    run_edges(1);
    err_clear = 1'b0;
    check("clr_errch", 32'(err_ch),    32'd0);
    check("clr_error", 32'(error),     32'd0);
    check("clr_count", 32'(err_count), 32'd0);
    // Clear coinciding with the second mismatch: the mismatch wins.
    @(negedge clk); inj_ch = 4'b0100;
    run_edges(1);
    inj_ch = '0;
    run_edges(8);
    check("sw_first", 32'(err_count), 32'd1);
    err_clear = 1'b1;
    run_edges(1);
    err_clear = 1'b0;
    check("sw_count", 32'(err_count), 32'd1);
    check("sw_errch", 32'(err_ch),    32'h4);
    run_edges(3);
    check("sw_after", 32'(err_count), 32'd1);
`endif

    // Asynchronous reset mid-run clears outputs without waiting for a clock.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_cnt",   32'(active_cnt), 32'd0);
    check("arst_busy",  32'(busy),       32'd0);
    check("arst_error", 32'(error),      32'd0);
    check("arst_errch", 32'(err_ch),     32'd0);
    check("arst_count", 32'(err_count),  32'd0);
    enable  = 1'b0;
    ch_mask = '0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Random enable/mask traffic against the model; no errors may ever appear.
    hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check("rnd_cnt",   32'(active_cnt), 32'(m_on.size()));
      check("rnd_busy",  32'(busy),       32'(m_phase != 0));
      check("rnd_error", 32'(error),      32'd0);
      check("rnd_count", 32'(err_count),  32'd0);
      if (hold == 0) begin
        enable = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) ch_mask = NCH'($urandom);
        hold = $urandom_range(1, 60);
      end
      hold--;
      @(posedge clk);
      model_step(enable, ch_mask);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
